// File: rtl/latch_bank_arbiter.sv
// latch_bank_arbiter: arbitrates two write requesters onto a 4x4-bit latch bank (setup/strobe/hold). Rev 1.0
// Define LBA_ROUND_ROBIN_EN for round-robin tie-break; otherwise requester 0 has fixed priority.
`default_nettype none

module latch_bank_arbiter #(
  parameter int SETUP_CYCLES = 1,
  parameter int HOLD_CYCLES  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [1:0] addr0,
  input  logic [3:0] data0,
  output logic       gnt0,
  output logic       done0,
  input  logic       req1,
  input  logic [1:0] addr1,
  input  logic [3:0] data1,
  output logic       gnt1,
  output logic       done1,
  output logic [3:0] lat_d,
  output logic [3:0] lat_en,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_STROBE = 2'd2,
    S_HOLD   = 2'd3
  } state_e;

  // Counters count down to zero, so each phase loads its length minus one.
  localparam logic [3:0] c_SETUP_LOAD = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] c_HOLD_LOAD  = 4'(HOLD_CYCLES - 1);

  state_e     state_q;
  logic [3:0] cnt_q;
  logic [1:0] addr_q;
  logic       who_q;
  logic [3:0] lat_d_q;
  logic [3:0] lat_en_q;
  logic [1:0] gnt_q;
  logic [1:0] done_q;
  logic       busy_q;

  logic       w_any;
  logic       w_win;

  assign w_any = req0 | req1;

`ifdef LBA_ROUND_ROBIN_EN
  logic last_q;

  // Pointer starts at requester 1 so requester 0 takes the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (state_q == S_IDLE && w_any) begin
      last_q <= w_win;
    end
  end

  assign w_win = (req0 && req1) ? ~last_q : req1;
`else
  assign w_win = ~req0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      addr_q   <= 2'd0;
      who_q    <= 1'b0;
      lat_d_q  <= 4'd0;
      lat_en_q <= 4'd0;
      gnt_q    <= 2'b00;
      done_q   <= 2'b00;
      busy_q   <= 1'b0;
    end else begin
      gnt_q    <= 2'b00;
      done_q   <= 2'b00;
      lat_en_q <= 4'd0;
      case (state_q)
        S_IDLE: begin
          if (w_any) begin
            state_q <= S_SETUP;
            busy_q  <= 1'b1;
            cnt_q   <= c_SETUP_LOAD;
            who_q   <= w_win;
            addr_q  <= w_win ? addr1 : addr0;
            lat_d_q <= w_win ? data1 : data0;
            gnt_q   <= w_win ? 2'b10 : 2'b01;
          end
        end
        S_SETUP: begin
          if (cnt_q == 4'd0) begin
            state_q  <= S_STROBE;
            lat_en_q <= 4'b0001 << addr_q;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_STROBE: begin
          state_q <= S_HOLD;
          cnt_q   <= c_HOLD_LOAD;
        end
        S_HOLD: begin
          if (cnt_q == 4'd0) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= who_q ? 2'b10 : 2'b01;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt0   = gnt_q[0];
  assign gnt1   = gnt_q[1];
  assign done0  = done_q[0];
  assign done1  = done_q[1];
  assign lat_d  = lat_d_q;
  assign lat_en = lat_en_q;
  assign busy   = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_latch_bank_arbiter.sv
// tb_latch_bank_arbiter: randomized scoreboard bench for latch_bank_arbiter, plus a directed run of a 3/2-cycle instance.
// Honours LBA_ROUND_ROBIN_EN the same way the design does.
`default_nettype none

module tb_latch_bank_arbiter;

  localparam int SETUP = 1;
  localparam int HOLD  = 1;
`ifdef LBA_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    int         cyc;
    int         who;
    logic [1:0] addr;
    logic [3:0] data;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] rq  = 2'b00;
  logic [1:0] ad [2];
  logic [3:0] dt [2];
  logic       gnt0, gnt1, done0, done1, busy;
  logic [3:0] lat_d, lat_en;

  logic       b_req0 = 1'b0, b_req1 = 1'b0;
  logic [1:0] b_addr0 = 2'd0, b_addr1 = 2'd0;
  logic [3:0] b_data0 = 4'd0, b_data1 = 4'd0;
  logic       b_gnt0, b_gnt1, b_done0, b_done1, b_busy;
  logic [3:0] b_lat_d, b_lat_en;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: per-transaction timing from the phase lengths, nothing cycle-stepped.
  int         cyc = 0;
  int         free_cyc = 0;
  bit         last = 1'b1;
  logic [3:0] mdl_latd = 4'd0;
  bit         gnt_now = 1'b0;
  int         gnt_who = 0;
  ev_t        gq[$], sq[$], dq[$];

  bit auto_en = 1'b0;
  bit sticky  = 1'b0;
  int pct     = 0;
  bit mon_en  = 1'b0;

  always #5 clk = ~clk;

  latch_bank_arbiter #(.SETUP_CYCLES(SETUP), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst(rst),
    .req0(rq[0]), .addr0(ad[0]), .data0(dt[0]), .gnt0(gnt0), .done0(done0),
    .req1(rq[1]), .addr1(ad[1]), .data1(dt[1]), .gnt1(gnt1), .done1(done1),
    .lat_d(lat_d), .lat_en(lat_en), .busy(busy)
  );

  latch_bank_arbiter #(.SETUP_CYCLES(3), .HOLD_CYCLES(2)) dut_b (
    .clk(clk), .rst(rst),
    .req0(b_req0), .addr0(b_addr0), .data0(b_data0), .gnt0(b_gnt0), .done0(b_done0),
    .req1(b_req1), .addr1(b_addr1), .data1(b_data1), .gnt1(b_gnt1), .done1(b_done1),
    .lat_d(b_lat_d), .lat_en(b_lat_en), .busy(b_busy)
  );

  task automatic model_update();
    ev_t ev;
    int  w;
    cyc++;
    gnt_now = 1'b0;
    if (rst) begin
      free_cyc = cyc;
      mdl_latd = 4'd0;
      last     = 1'b1;
      gq.delete();
      sq.delete();
      dq.delete();
    end else if ((cyc - 1) >= free_cyc && (rq[0] || rq[1])) begin
      if (rq[0] && rq[1]) w = RR ? (last ? 0 : 1) : 0;
      else                w = rq[1] ? 1 : 0;
      ev.who  = w;
      ev.addr = ad[w];
      ev.data = dt[w];
      ev.cyc  = cyc;                    gq.push_back(ev);
      ev.cyc  = cyc + SETUP;            sq.push_back(ev);
      ev.cyc  = cyc + SETUP + HOLD + 1; dq.push_back(ev);
      free_cyc = cyc + SETUP + HOLD + 1;
      mdl_latd = dt[w];
      last     = (w == 1);
      gnt_now  = 1'b1;
      gnt_who  = w;
    end
  endtask

  task automatic agents();
    for (int i = 0; i < 2; i++) begin
      if (gnt_now && gnt_who == i) begin
        rq[i] = sticky;
        ad[i] = 2'($urandom_range(3));
        dt[i] = 4'($urandom_range(15));
      end else if (!rq[i]) begin
        ad[i] = 2'($urandom_range(3));
        dt[i] = 4'($urandom_range(15));
        if (int'($urandom_range(99)) < pct) rq[i] = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #2;
    if (auto_en) agents();
  endtask

  task automatic wait_gnt(input int who);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!(gnt_now && gnt_who == who) && n < 40);
    if (!(gnt_now && gnt_who == who)) begin
      n_fail++;
      $display("FAIL wait_gnt%0d: no grant to requester %0d within %0d cycles", who, who, n);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((cyc < free_cyc || gq.size() != 0 || sq.size() != 0 || dq.size() != 0) && n < 60) begin
      tick();
      n++;
    end
    tick();
    n_chk++;
    if (n >= 60) begin
      n_fail++;
      $display("FAIL drain: still busy after %0d cycles, pending gnt=%0d strobe=%0d done=%0d", n, gq.size(), sq.size(), dq.size());
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT shows an event, flags overdue ones.
  always @(negedge clk) begin
    ev_t e;
    if (mon_en) begin
      if (gnt0 || gnt1) begin
        n_chk++;
        if (gq.size() == 0) begin
          n_fail++;
          $display("FAIL gnt_unexpected: gnt0=%0b gnt1=%0b at cycle %0d, none required", gnt0, gnt1, cyc);
        end else begin
          e = gq.pop_front();
          if (e.cyc != cyc || gnt0 != (e.who == 0) || gnt1 != (e.who == 1)) begin
            n_fail++;
            $display("FAIL gnt: got gnt0=%0b gnt1=%0b at cycle %0d, required requester %0d at cycle %0d", gnt0, gnt1, cyc, e.who, e.cyc);
          end
        end
      end else if (gq.size() != 0 && gq[0].cyc <= cyc) begin
        e = gq.pop_front();
        n_chk++; n_fail++;
        $display("FAIL gnt_missing: got none at cycle %0d, required requester %0d at cycle %0d", cyc, e.who, e.cyc);
      end

      if (lat_en != 4'd0) begin
        n_chk++;
        if (sq.size() == 0) begin
          n_fail++;
          $display("FAIL strobe_unexpected: lat_en=%b at cycle %0d, required 0000", lat_en, cyc);
        end else begin
          e = sq.pop_front();
          if (e.cyc != cyc || lat_en != (4'b0001 << e.addr) || lat_d != e.data) begin
            n_fail++;
            $display("FAIL strobe: got lat_en=%b lat_d=%b at cycle %0d, required lat_en=%b lat_d=%b at cycle %0d", lat_en, lat_d, cyc, 4'b0001 << e.addr, e.data, e.cyc);
          end
        end
      end else if (sq.size() != 0 && sq[0].cyc <= cyc) begin
        e = sq.pop_front();
        n_chk++; n_fail++;
        $display("FAIL strobe_missing: lat_en=0000 at cycle %0d, required %b at cycle %0d", cyc, 4'b0001 << e.addr, e.cyc);
      end

      if (done0 || done1) begin
        n_chk++;
        if (dq.size() == 0) begin
          n_fail++;
          $display("FAIL done_unexpected: done0=%0b done1=%0b at cycle %0d, none required", done0, done1, cyc);
        end else begin
          e = dq.pop_front();
          if (e.cyc != cyc || done0 != (e.who == 0) || done1 != (e.who == 1)) begin
            n_fail++;
            $display("FAIL done: got done0=%0b done1=%0b at cycle %0d, required requester %0d at cycle %0d", done0, done1, cyc, e.who, e.cyc);
          end
        end
      end else if (dq.size() != 0 && dq[0].cyc <= cyc) begin
        e = dq.pop_front();
        n_chk++; n_fail++;
        $display("FAIL done_missing: got none at cycle %0d, required requester %0d at cycle %0d", cyc, e.who, e.cyc);
      end

      n_chk++;
      if (lat_d !== mdl_latd) begin
        n_fail++;
        $display("FAIL lat_d: got %b at cycle %0d, required %b", lat_d, cyc, mdl_latd);
      end
      n_chk++;
      if (busy !== (cyc < free_cyc)) begin
        n_fail++;
        $display("FAIL busy: got %b at cycle %0d, required %b", busy, cyc, (cyc < free_cyc));
      end
      n_chk++;
      if (!$onehot0(lat_en) || (gnt0 && gnt1) || (done0 && done1)) begin
        n_fail++;
        $display("FAIL exclusivity: lat_en=%b gnt=%b%b done=%b%b at cycle %0d, required one-hot-or-zero and single gnt/done", lat_en, gnt1, gnt0, done1, done0, cyc);
      end
    end
  end

  initial begin
    logic [16:0] got;
    logic [16:0] exp;
    ad[0] = 2'd0; ad[1] = 2'd0;
    dt[0] = 4'd0; dt[1] = 4'd0;

    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    n_chk++;
    if ({gnt0, gnt1, done0, done1, busy, lat_en, lat_d} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_state: got gnt=%b%b done=%b%b busy=%b lat_en=%b lat_d=%b, required all zero", gnt1, gnt0, done1, done0, busy, lat_en, lat_d);
    end
    n_chk++;
    if ({b_gnt0, b_gnt1, b_done0, b_done1, b_busy, b_lat_en, b_lat_d} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_state_b: got busy=%b lat_en=%b lat_d=%b, required all zero", b_busy, b_lat_en, b_lat_d);
    end
    rst    = 1'b0;
    mon_en = 1'b1;

    // Single write to word 2.
    rq[0] = 1'b1; ad[0] = 2'd2; dt[0] = 4'b1011;
    wait_gnt(0);
    rq[0] = 1'b0; dt[0] = 4'b0000; ad[0] = 2'd0;
    drain();

    // Inputs change right after the grant; the captured word must persist.
    rq[0] = 1'b1; ad[0] = 2'd1; dt[0] = 4'b0001;
    wait_gnt(0);
    rq[0] = 1'b0;
    tick();
    dt[0] = 4'b1110; ad[0] = 2'd3;
    drain();

    // Both requesters held high continuously.
    auto_en = 1'b1; sticky = 1'b1; pct = 100;
    repeat (40) tick();
    sticky = 1'b0; pct = 30;
    repeat (400) tick();
    auto_en = 1'b0; rq = 2'b00;
    drain();

    // Reset landing on the strobe cycle abandons the write.
    rq[1] = 1'b1; ad[1] = 2'd3; dt[1] = 4'b0101;
    wait_gnt(1);
    rq[1] = 1'b0;
    repeat (SETUP) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if (lat_en !== 4'd0 || lat_d !== 4'd0) begin
      n_fail++;
      $display("FAIL strobe_reset: got lat_en=%b lat_d=%b, required 0000 0000", lat_en, lat_d);
    end

    // First tie after reset goes to requester 0 in both builds.
    rq = 2'b11; ad[0] = 2'd0; dt[0] = 4'b0011; ad[1] = 2'd2; dt[1] = 4'b1100;
    wait_gnt(0);
    rq[0] = 1'b0;
    wait_gnt(1);
    rq[1] = 1'b0;
    drain();

    // 3-cycle setup / 2-cycle hold instance: strobe 4 and done 7 cycles after the request cycle.
    b_req1 = 1'b1; b_addr1 = 2'd0; b_data1 = 4'b0110;
    for (int j = 0; j < 9; j++) begin
      tick();
      if (j == 0) begin
        b_req1 = 1'b0; b_data1 = 4'b1001; b_addr1 = 2'd3;
      end
      @(negedge clk);
      got = {b_gnt0, b_gnt1, b_done0, b_done1, b_busy, b_lat_en, b_lat_d, 4'd0};
      exp = {1'b0, (j == 0), 1'b0, (j == 6), (j <= 5), ((j == 3) ? 4'b0001 : 4'b0000), 4'b0110, 4'd0};
      n_chk++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL b_cycle%0d: got gnt=%b%b done=%b%b busy=%b lat_en=%b lat_d=%b, required gnt=%b%b done=%b%b busy=%b lat_en=%b lat_d=%b",
                 j, got[15], got[16], got[13], got[14], got[12], got[11:8], got[7:4],
                 exp[15], exp[16], exp[13], exp[14], exp[12], exp[11:8], exp[7:4]);
      end
    end

    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/latch_bank_arbiter.md
LATCH_BANK_ARBITER -- requirements
Module: latch_bank_arbiter

Interface
REQ-001 Parameter SETUP_CYCLES, default 1: cycles lat_d is stable before the strobe; legal range 1..15.
REQ-002 Parameter HOLD_CYCLES, default 1: cycles lat_d is held after the strobe; legal range 1..15.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req0  input  1  requester 0 write request; level, held until gnt0.
REQ-006 addr0  input  2  requester 0 target word (0..3).
REQ-007 data0  input  4  requester 0 write data.
REQ-008 gnt0  output  1  one-cycle pulse: requester 0 accepted, addr0/data0 captured.
REQ-009 done0  output  1  one-cycle pulse: requester 0 write complete.
REQ-010 req1, addr1, data1, gnt1, done1: same widths and meanings for requester 1.
REQ-011 lat_d  output  4  shared data bus to the D inputs of all four 4-bit latch words.
REQ-012 lat_en  output  4  per-word latch enable, one-hot or zero.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 FSM states IDLE, SETUP, STROBE, HOLD; all outputs registered.
REQ-015 IDLE: if any req is high at an edge, arbitrate, capture the winner's addr/data, pulse its gnt in the next cycle, go to SETUP.
REQ-016 SETUP: lat_d = captured data, lat_en = 0; lasts SETUP_CYCLES cycles, then STROBE.
REQ-017 STROBE: exactly one cycle; lat_en[captured addr] = 1, all other bits 0, lat_d unchanged.
REQ-018 HOLD: lat_en = 0, lat_d unchanged; lasts HOLD_CYCLES cycles, then IDLE with done of the granted requester pulsed for one cycle.
REQ-019 Latency req-sampled to done: SETUP_CYCLES + HOLD_CYCLES + 2 cycles; default parameters give 4 cycles.
REQ-020 In IDLE, lat_d retains the last written value and lat_en = 0.
REQ-021 The IDLE cycle carrying a done pulse also arbitrates, so back-to-back writes run with no idle gap.
REQ-022 Requests arriving while busy are ignored until IDLE.
REQ-023 A requester whose req is still high in the done cycle is treated as a new request.
REQ-024 addr/data changes after the grant have no effect on the write in progress.
REQ-025 The setup and hold counters are 4 bits wide and reload per phase; they do not wrap mid-phase.
REQ-026 lat_en is never multi-hot and is never high outside STROBE.
REQ-027 gnt0/gnt1 and done0/done1 are never high in the same cycle.

Reset
REQ-028 While rst is high at an edge, the block goes to IDLE with lat_d = 0, lat_en = 0, busy = 0, and all gnt/done = 0.
REQ-029 Reset also returns the last-grant pointer to requester 1, so requester 0 wins the first tie.
REQ-030 A reset mid-operation, including during STROBE, abandons the write: lat_en drops at that edge and no done pulse is issued.

Configuration
REQ-031 Macro LBA_ROUND_ROBIN_EN controls the tie-break when both requests are high.
REQ-032 With LBA_ROUND_ROBIN_EN defined, ties go to the requester not granted last.
REQ-033 Without LBA_ROUND_ROBIN_EN, requester 0 always wins ties (fixed priority).
REQ-034 A single request is granted identically in both builds.

Verification
REQ-035 Reset then req0=1, addr0=2, data0=4'b1011 (defaults) -> gnt0 at cycle+1; lat_en=4'b0100 exactly one cycle at cycle+2; done0 at cycle+4; lat_d=4'b1011 through HOLD.
REQ-036 req0 and req1 held high continuously, LBA_ROUND_ROBIN_EN defined -> grants alternate 0,1,0,1 with no idle cycle between writes; undefined -> only requester 0 is granted.
REQ-037 SETUP_CYCLES=3, HOLD_CYCLES=2, req1 with addr1=0 -> lat_en=4'b0001 starts 4 cycles after the request is sampled; done1 at cycle+7.
REQ-038 rst pulsed during STROBE -> lat_en=0 and lat_d=0 at the next edge; no done pulse; the next request starts cleanly from IDLE.
REQ-039 data0 changed from 4'b0001 to 4'b1110 in the cycle after gnt0 -> lat_d stays 4'b0001 through HOLD.
REQ-040 Every test: assert lat_en is never multi-hot, at most one gnt and one done are high per cycle, and busy=0 exactly in IDLE.
